systolic_feed_ctrl: RTL and testbench
=====================================

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 Parameter SIZE, default 6: array dimension N, giving an N x N systolic array and N lanes per edge.
REQ-002 Parameter DATA_WIDTH, default 32: operand element width.
REQ-003 Parameter TIMEOUT_CYCLES, default 256: watchdog limit in DRAIN; used only when FEED_TIMEOUT_EN is defined.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  request one matrix multiply; accepted only in IDLE.
REQ-008 busy  out  1  high from the cycle after acceptance until the cycle done is high, inclusive.
REQ-009 done  out  1  one-cycle completion pulse.
REQ-010 error  out  1  timeout flag, valid while done is high.
REQ-011 a_rd_en / b_rd_en  out  1  operand memory read strobes.
REQ-012 rd_addr  out  clog2(SIZE)  column index k, shared by both memories.
REQ-013 a_rd_data  in  SIZE*DATA_WIDTH  lane i = A[i][k]; synchronous, 1-cycle read latency.
REQ-014 b_rd_data  in  SIZE*DATA_WIDTH  lane j = B[k][j]; synchronous, 1-cycle read latency.
REQ-015 array_clr  out  1  drives the array's rst.
REQ-016 west_o / north_o  out  SIZE*DATA_WIDTH  packed lanes to the array's inp_west / inp_north; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-017 array_done  in  1  the array's done output.

Function
REQ-018 The FSM SHALL have five states, IDLE, CLEAR, FEED, DRAIN and FIN, all fully registered.
REQ-019 If start is sampled high in IDLE at cycle C0, the FSM SHALL be in CLEAR at C1, with array_clr=1 for exactly that one cycle.
REQ-020 In FEED, slot counter t SHALL run 0..3*SIZE-1, one increment per cycle, beginning at C2.
REQ-021 In FEED, a_rd_en, b_rd_en and rd_addr SHALL equal (t<SIZE), (t<SIZE) and t; outside FEED the strobes are 0 and rd_addr is 0.
REQ-022 Stream slot s (s=0..3*SIZE-1) SHALL appear on west_o and north_o during cycle C3+s.
REQ-023 In slot s, west lane i = A[i][s-i] if 0<=s-i<SIZE, else 0.
REQ-024 In slot s, north lane j = B[s-j][j] if 0<=s-j<SIZE, else 0.
REQ-025 The skew SHALL be built from per-lane delay registers: lane i is delayed i cycles after the memory output register.
REQ-026 west_o and north_o SHALL be all-zero in every cycle outside the slot window.
REQ-027 The FSM SHALL enter DRAIN on the cycle after slot 3*SIZE-1.
REQ-028 array_done SHALL be ignored outside DRAIN, so a stale done asserted before array_clr takes effect is never taken as completion.
REQ-029 In DRAIN, array_done=1 SHALL move the FSM to FIN on the next cycle.
REQ-030 In FIN, done=1 for one cycle with error=0; the FSM returns to IDLE on the next cycle.
REQ-031 start while busy=1 SHALL be ignored, with no queuing.
REQ-032 start held high continuously SHALL launch a new operation on the first IDLE cycle after each done pulse.
REQ-033 No arithmetic is performed; operand bits pass through unmodified.

Reset
REQ-034 While rst=1 the block SHALL hold: state=IDLE, t=0, busy=0, done=0, error=0, rd strobes=0, rd_addr=0, west_o=0, north_o=0, all skew registers=0, array_clr=1.
REQ-035 rst asserted mid-operation SHALL abort the operation: the next cycle after rst deasserts is IDLE, with no done pulse.

Configuration
REQ-036 With macro FEED_TIMEOUT_EN defined, a DRAIN cycle counter SHALL force FIN with done=1 and error=1 once TIMEOUT_CYCLES cycles pass without array_done.
REQ-037 With FEED_TIMEOUT_EN undefined, DRAIN waits indefinitely, error is tied 0, and no counter is synthesised.

Verification
REQ-038 Memories loaded with A[i][k]=6i+k+1 and B[k][j]=(k+1)(j+1), SIZE=6, start pulse -> west lane 2 = 13 at slot 2, north lane 5 = 6 at slot 5, array result[0][0] = 91, one done pulse, error=0.
REQ-039 Same load, observe busy -> high exactly from C1 through the done cycle; array_clr high only during C1.
REQ-040 Second start pulse at slot 4 -> ignored; the stream is identical to REQ-038 and exactly one done pulse occurs.
REQ-041 rst pulsed at slot 7 -> all outputs zero the next cycle, FSM idle, no done; a fresh start then yields the REQ-038 results.
REQ-042 With FEED_TIMEOUT_EN defined, TIMEOUT_CYCLES=20 and array_done held 0 -> done=1 with error=1 in the 21st cycle after DRAIN entry.
REQ-043 array_done forced 1 throughout, start pulse -> FIN is reached only after all 18 slots have been streamed, never earlier.

Source files
------------

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - operand feed sequencer for an N x N systolic array
// Optional DRAIN watchdog enabled by defining FEED_TIMEOUT_EN.
module systolic_feed_ctrl #(
    parameter int SIZE           = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic                         a_rd_en,
    output logic                         b_rd_en,
    output logic [AW-1:0]                rd_addr,
    input  logic [SIZE*DATA_WIDTH-1:0]   a_rd_data,
    input  logic [SIZE*DATA_WIDTH-1:0]   b_rd_data,
    output logic                         array_clr,
    output logic [SIZE*DATA_WIDTH-1:0]   west_o,
    output logic [SIZE*DATA_WIDTH-1:0]   north_o,
    input  logic                         array_done
);
    localparam int TW = $clog2(3 * SIZE);
    localparam logic [TW-1:0] T_N    = TW'(SIZE);
    localparam logic [TW-1:0] T_LAST = TW'(3 * SIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_FIN} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   t_q, t_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            clr_q, clr_d;
    logic            rd_en_q, rd_en_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic            valid_q, valid_d;

`ifdef FEED_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            error_q, error_d;
`endif

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
`ifdef FEED_TIMEOUT_EN
        cnt_d   = '0;
        error_d = 1'b0;
`endif
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d = S_FEED;
                t_d     = '0;
            end
            S_FEED: begin
                if (t_q == T_LAST) begin
                    state_d = S_DRAIN;
                    t_d     = '0;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            // array_done is only trusted here; earlier it may be stale from the last job
            S_DRAIN: begin
`ifdef FEED_TIMEOUT_EN
                if (array_done) begin
                    state_d = S_FIN;
                end else if (cnt_q == C_LAST) begin
                    state_d = S_FIN;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                if (array_done) state_d = S_FIN;
`endif
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FIN);
        clr_d     = (state_d == S_CLEAR);
        rd_en_d   = (state_d == S_FEED) && (t_d < T_N);
        rd_addr_d = rd_en_d ? t_d[AW-1:0] : '0;
        valid_d   = rd_en_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            t_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            clr_q     <= 1'b1;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
`ifdef FEED_TIMEOUT_EN
            cnt_q     <= '0;
            error_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            clr_q     <= clr_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            valid_q   <= valid_d;
`ifdef FEED_TIMEOUT_EN
            cnt_q     <= cnt_d;
            error_q   <= error_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign array_clr = clr_q;
    assign a_rd_en   = rd_en_q;
    assign b_rd_en   = rd_en_q;
    assign rd_addr   = rd_addr_q;

`ifdef FEED_TIMEOUT_EN
    assign error = error_q;
`else
    assign error = 1'b0;
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    end
`endif

    // Memory data is gated by the delayed read strobe so stale read data never leaks out.
    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [DATA_WIDTH-1:0] a_in, b_in;
        assign a_in = valid_q ? a_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign b_in = valid_q ? b_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;

        if (i == 0) begin : g_direct
            assign west_o[i*DATA_WIDTH +: DATA_WIDTH]  = a_in;
            assign north_o[i*DATA_WIDTH +: DATA_WIDTH] = b_in;
        end else begin : g_dly
            logic [DATA_WIDTH-1:0] wd_q [i];
            logic [DATA_WIDTH-1:0] wd_d [i];
            logic [DATA_WIDTH-1:0] nd_q [i];
            logic [DATA_WIDTH-1:0] nd_d [i];

            always_comb begin
                wd_d[0] = a_in;
                nd_d[0] = b_in;
                for (int k = 1; k < i; k++) begin
                    wd_d[k] = wd_q[k-1];
                    nd_d[k] = nd_q[k-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wd_q <= '{default: '0};
                    nd_q <= '{default: '0};
                end else begin
                    wd_q <= wd_d;
                    nd_q <= nd_d;
                end
            end

            assign west_o[i*DATA_WIDTH +: DATA_WIDTH]  = wd_q[i-1];
            assign north_o[i*DATA_WIDTH +: DATA_WIDTH] = nd_q[i-1];
        end
    end
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - scoreboard bench for systolic_feed_ctrl
module tb_systolic_feed_ctrl;
    localparam int N     = 6;
    localparam int DW    = 32;
    localparam int TO    = 20;
    localparam int NSLOT = 3 * N;
    localparam int AW    = 3;

    logic              clk, rst, start, array_done;
    logic              busy, done, error, a_rd_en, b_rd_en, array_clr;
    logic [AW-1:0]     rd_addr;
    logic [N*DW-1:0]   a_rd_data, b_rd_data, west_o, north_o;

    systolic_feed_ctrl #(.SIZE(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en), .rd_addr(rd_addr),
        .a_rd_data(a_rd_data), .b_rd_data(b_rd_data), .array_clr(array_clr),
        .west_o(west_o), .north_o(north_o), .array_done(array_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                  c0;
        int                  fin;
        bit                  err;
        logic [N*N*DW-1:0]   a;
        logic [N*N*DW-1:0]   b;
    } op_t;

    op_t               opq[$];
    logic [N*N*DW-1:0] mem_a, mem_b;
    int                cyc = 0;
    bit                rst_seen = 1'b0;
    bit                mon_active = 1'b0;
    int                vectors = 0;
    int                miscompares = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Operand memories: 1-cycle synchronous read, data held when not enabled.
    always @(posedge clk) begin
        if (a_rd_en)
            for (int i = 0; i < N; i++)
                a_rd_data[i*DW +: DW] <= mem_a[(i*N + int'(rd_addr))*DW +: DW];
        if (b_rd_en)
            for (int j = 0; j < N; j++)
                b_rd_data[j*DW +: DW] <= mem_b[(int'(rd_addr)*N + j)*DW +: DW];
    end

    task automatic check(input string nm, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Skewed edge stream: slot s, lane l carries element k = s - l.
    function automatic logic [N*DW-1:0] exp_edge(input logic [N*N*DW-1:0] m, input int s, input bit is_b);
        logic [N*DW-1:0] r;
        r = '0;
        if (s >= 0 && s < NSLOT)
            for (int l = 0; l < N; l++) begin
                int k;
                k = s - l;
                if (k >= 0 && k < N)
                    r[l*DW +: DW] = is_b ? m[(k*N + l)*DW +: DW] : m[(l*N + k)*DW +: DW];
            end
        return r;
    endfunction

    initial begin : monitor
        op_t cur;
        int  d;
        logic e_busy, e_done, e_err, e_clr, e_rden;
        logic [AW-1:0] e_addr;
        bit chk_addr;
        logic [N*DW-1:0] e_w, e_n;
        forever begin
            @(negedge clk);
            if (cyc == 0) continue;
            if (!mon_active && opq.size() > 0 && opq[0].c0 == cyc) begin
                cur = opq.pop_front();
                mon_active = 1'b1;
            end
            e_busy = 0; e_done = 0; e_err = 0; e_clr = 0; e_rden = 0;
            e_addr = '0; chk_addr = 1; e_w = '0; e_n = '0;
            if (rst_seen) begin
                mon_active = 1'b0;
                e_clr = 1;
            end else if (mon_active) begin
                d      = cyc - cur.c0;
                e_busy = (d >= 1 && d <= cur.fin);
                e_done = (d == cur.fin);
                e_err  = e_done && cur.err;
                e_clr  = (d == 1);
                e_rden = (d >= 2 && d < 2 + N);
                if (e_rden) e_addr = AW'(d - 2);
                else if (d >= 2 && d < 2 + NSLOT) chk_addr = 0;
                e_w = exp_edge(cur.a, d - 3, 1'b0);
                e_n = exp_edge(cur.b, d - 3, 1'b1);
                if (d == cur.fin) mon_active = 1'b0;
            end
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("error", error, e_err);
            check("array_clr", array_clr, e_clr);
            check("a_rd_en", a_rd_en, e_rden);
            check("b_rd_en", b_rd_en, e_rden);
            if (chk_addr) check("rd_addr", rd_addr, e_addr);
            check("west_o", west_o, e_w);
            check("north_o", north_o, e_n);
        end
    end

    task automatic fill(input bit pattern);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                mem_a[(i*N + k)*DW +: DW] = pattern ? DW'(6*i + k + 1) : $urandom;
                mem_b[(k*N + i)*DW +: DW] = pattern ? DW'((k + 1)*(i + 1)) : $urandom;
            end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
        end
    endtask

    // dmode: 0 done pulse, 1 stale done early + pulse, 2 done held high, 3 never done (watchdog)
    task automatic run_op(input bit pattern, input int w, input int dmode,
                          input int extra_d, input int rst_d, input bit keep);
        op_t o;
        fill(pattern);
        o.c0  = cyc;
        o.fin = (dmode == 3) ? NSLOT + 2 + TO : NSLOT + 3 + w;
        o.err = (dmode == 3);
        o.a   = mem_a;
        o.b   = mem_b;
        opq.push_back(o);
        for (int d = 0; d <= o.fin; d++) begin
            start = keep || d == 0 || d == extra_d;
            case (dmode)
                0:       array_done = (d == 2 + NSLOT + w);
                1:       array_done = (d == 2 + NSLOT + w) || d < 6;
                2:       array_done = 1'b1;
                default: array_done = (d < 5);
            endcase
            rst = (d == rst_d);
            @(posedge clk); #1;
            if (d == rst_d) break;
        end
        rst = 1'b0;
        array_done = 1'b0;
        if (!keep) start = 1'b0;
    endtask

    initial begin : stim
        int w;
        rst = 1'b1; start = 1'b0; array_done = 1'b0;
        mem_a = '0; mem_b = '0;
        a_rd_data = {N{32'hdead_beef}};
        b_rd_data = {N{32'hcafe_f00d}};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        run_op(1, 4, 0, -1, -1, 0);
        idle(3);
        run_op(1, 2, 0, 7, -1, 0);
        idle(2);
        run_op(1, 3, 0, -1, 10, 0);
        idle(2);
        run_op(1, 1, 0, -1, -1, 0);
        run_op(0, 0, 2, -1, -1, 0);
        idle(1);
        run_op(0, 5, 1, -1, -1, 0);
        run_op(0, 3, 0, -1, -1, 1);
        run_op(0, 1, 0, -1, -1, 0);
        for (int r = 0; r < 6; r++) begin
            w = $urandom_range(0, 12);
            run_op(0, w, $urandom_range(0, 1),
                   ($urandom_range(0, 1) == 1) ? $urandom_range(1, NSLOT + 3 + w) : -1, -1, 0);
            idle($urandom_range(0, 3));
        end
`ifdef FEED_TIMEOUT_EN
        run_op(0, 0, 3, -1, -1, 0);
`endif
        idle(3);
        check("scoreboard_drained", 192'(opq.size() + int'(mon_active)), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
